// File: rtl/delay_ram_rd_if.sv
// Sample-stream bundle between a producer and the runtime-programmable RAM delay line.
// Latency: none; this file only groups wires.
// Backpressure: none; strobe-driven, the consumer must accept every output strobe.
interface delay_ram_rd_if #(
    parameter int WIDTH = 24,
    parameter int AW    = 10
);
    logic             en_i;
    logic [WIDTH-1:0] d_i;
    logic [AW-1:0]    delay_i;
    logic             vld_o;
    logic [WIDTH-1:0] d_o;

    // Sample source: drives strobe, data and requested delay.
    modport master (
        output en_i,
        output d_i,
        output delay_i,
        input  vld_o,
        input  d_o
    );

    // Delay line: consumes strobes, returns delayed samples.
    modport slave (
        input  en_i,
        input  d_i,
        input  delay_i,
        output vld_o,
        output d_o
    );
endinterface

// File: rtl/delay_ram_rd.sv
// Runtime-programmable circular-RAM delay line; delay counted in en_i strobes (0 acts as 1).
// Latency 1 cycle from strobe to vld_o/d_o, 2 cycles when DELAY_RAM_OREG_EN is defined.
// No backpressure: one write and one read per strobe; d_o holds while vld_o is low.
module delay_ram_rd #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 1024
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    delay_ram_rd_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] FILL_MAX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    // Sample storage; deliberately not reset, stale entries are masked by fill.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    fill;
    logic [AW-1:0]    delay_q;
    logic             en_q;
    logic             hit_q;
    logic [WIDTH-1:0] rd_q;

    logic [AW-1:0]    dly_eff;
    logic             dly_chg;
    logic [AW-1:0]    raddr;
    logic             rd_en;
    logic             vld_s1;

    // Clamp the requested delay, detect a change, and form the read tap.
    always_comb begin
        dly_eff = (bus.delay_i == '0) ? ONE : bus.delay_i;
        dly_chg = (dly_eff != delay_q);
        // DEPTH is a power of two, so the AW-bit subtraction wraps modulo DEPTH.
        raddr   = wptr - delay_q;
        // Read only when enough samples since the last flush exist to cover the tap.
        rd_en   = bus.en_i && !dly_chg && (fill >= delay_q);
    end

    // Write pointer, fill counter and effective delay; a delay change flushes fill.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr    <= '0;
            fill    <= '0;
            delay_q <= ONE;
        end else begin
            if (bus.en_i) begin
                wptr <= wptr + ONE;
            end
            if (dly_chg) begin
                delay_q <= dly_eff;
                fill    <= '0;
            end else if (bus.en_i && (fill != FILL_MAX)) begin
                fill <= fill + ONE;
            end
        end
    end

    // RAM write port; the tap is at least one behind wptr so no bypass is needed.
    always_ff @(posedge clk_i) begin
        if (bus.en_i) begin
            mem[wptr] <= bus.d_i;
        end
    end

    // Strobe and fill-sufficient flags, combined into the registered valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q  <= 1'b0;
            hit_q <= 1'b0;
        end else begin
            en_q  <= bus.en_i;
            hit_q <= !dly_chg && (fill >= delay_q);
        end
    end

    assign vld_s1 = en_q && hit_q;

    // Synchronous RAM read; only loads on a valid read so d_o holds otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem[raddr];
        end
    end

`ifdef DELAY_RAM_OREG_EN
    logic             vld_s2;
    logic [WIDTH-1:0] d_s2;

    // Extra retiming stage between RAM output and fabric; data holds when not valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_s2 <= 1'b0;
            d_s2   <= '0;
        end else begin
            vld_s2 <= vld_s1;
            if (vld_s1) begin
                d_s2 <= rd_q;
            end
        end
    end

    assign bus.vld_o = vld_s2;
    assign bus.d_o   = d_s2;
`else
    assign bus.vld_o = vld_s1;
    assign bus.d_o   = rd_q;
`endif

endmodule
